// File: rtl/res_station_pkg.sv
// Shared types for the reservation-station slice: FSM states, operand record, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Package tomasula_types
//   DATA_W / TAG_W / OP_W : default operand, ROB-tag and ALU-op widths
//   rs_state_t            : station occupancy state
//   operand_t             : one source operand {ready, value, producing tag}
package tomasula_types;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 3;
  localparam int OP_W   = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } rs_state_t;

  typedef struct packed {
    logic              rdy;
    logic [DATA_W-1:0] val;
    logic [TAG_W-1:0]  tag;
  } operand_t;

endpackage

// File: rtl/res_station_operand.sv
// One source-operand slot: captures value/tag at load, then snoops the CDB until resolved.
// Latency: a CDB hit is visible on val one cycle later; rdy_nxt is the combinational next ready bit.
// Backpressure: none; the owning station decides when capture and snooping are allowed.
//
// Ports
//   clk, rst                              : clock, synchronous active-high reset
//   load                                  : capture src_* this cycle (already qualified by the station)
//   src_rdy_i / src_val_i / src_tag_i     : incoming operand from the instruction queue
//   snoop                                 : station is waiting; CDB captures are allowed
//   cdb_valid_i / cdb_tag_i / cdb_val_i   : common data bus broadcast
//   rdy_nxt                               : ready bit as it will be after this clock edge
//   val                                   : held operand value
// Optional: RS_CDB_BYPASS_EN lets a same-cycle CDB broadcast resolve a pending operand at load.
module rs_operand #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              src_rdy_i,
  input  logic [DATA_W-1:0] src_val_i,
  input  logic [TAG_W-1:0]  src_tag_i,
  input  logic              snoop,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_val_i,
  output logic              rdy_nxt,
  output logic [DATA_W-1:0] val
);

  logic              rdy_q;
  logic [DATA_W-1:0] val_q;
  logic [TAG_W-1:0]  tag_q;
  logic              rdy_d;
  logic [DATA_W-1:0] val_d;
  logic [TAG_W-1:0]  tag_d;

  always_comb begin
    rdy_d = rdy_q;
    val_d = val_q;
    tag_d = tag_q;
    if (load) begin
      rdy_d = src_rdy_i;
      val_d = src_val_i;
      tag_d = src_tag_i;
`ifdef RS_CDB_BYPASS_EN
      // The producer is broadcasting in the very cycle we are loaded.
      if (!src_rdy_i && cdb_valid_i && (cdb_tag_i == src_tag_i)) begin
        rdy_d = 1'b1;
        val_d = cdb_val_i;
      end
`endif
    end else if (snoop && !rdy_q && cdb_valid_i && (cdb_tag_i == tag_q)) begin
      // Once resolved, later broadcasts of the same tag are stale and ignored.
      rdy_d = 1'b1;
      val_d = cdb_val_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q <= 1'b0;
      val_q <= '0;
      tag_q <= '0;
    end else begin
      rdy_q <= rdy_d;
      val_q <= val_d;
      tag_q <= tag_d;
    end
  end

  assign rdy_nxt = rdy_d;
  assign val     = val_q;

endmodule

// File: rtl/res_station.sv
// Single-entry Tomasulo reservation station: holds one op until both sources resolve, then issues.
// Latency: load->fu_valid_o 1 cycle if both sources ready; last CDB hit->fu_valid_o 1 cycle.
// Backpressure: fu_valid_o holds with stable op/operands/tag until fu_ready_i; empty only after fire.
//
// Ports
//   clk, rst                                  : clock, synchronous active-high reset (beats flush)
//   load, op_i, dest_tag_i, src{1,2}_*        : entry from the instruction queue, taken only when empty
//   cdb_valid_i, cdb_tag_i, cdb_val_i         : common data bus broadcast
//   flush_i                                   : squash the entry; beats load, CDB capture and fire
//   fu_ready_i                                : functional unit accepts the issued op
//   empty                                     : station free (to the queue's routing logic)
//   fu_valid_o, fu_op_o, fu_a_o, fu_b_o, fu_tag_o : issued operation
// Optional: define RS_CDB_BYPASS_EN to resolve pending sources from a CDB broadcast in the load cycle.
module res_station #(
  parameter int DATA_W = tomasula_types::DATA_W,
  parameter int TAG_W  = tomasula_types::TAG_W,
  parameter int OP_W   = tomasula_types::OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [OP_W-1:0]   op_i,
  input  logic [TAG_W-1:0]  dest_tag_i,
  input  logic              src1_rdy_i,
  input  logic [DATA_W-1:0] src1_val_i,
  input  logic [TAG_W-1:0]  src1_tag_i,
  input  logic              src2_rdy_i,
  input  logic [DATA_W-1:0] src2_val_i,
  input  logic [TAG_W-1:0]  src2_tag_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_val_i,
  input  logic              flush_i,
  input  logic              fu_ready_i,
  output logic              empty,
  output logic              fu_valid_o,
  output logic [OP_W-1:0]   fu_op_o,
  output logic [DATA_W-1:0] fu_a_o,
  output logic [DATA_W-1:0] fu_b_o,
  output logic [TAG_W-1:0]  fu_tag_o
);

  import tomasula_types::*;

  rs_state_t        state_q, state_d;
  logic [OP_W-1:0]  op_q;
  logic [TAG_W-1:0] dest_q;
  logic             load_acc;
  logic             snoop;
  logic             a_rdy_nxt, b_rdy_nxt;

  // A load is only honoured into an empty station; flush squashes it too.
  assign load_acc = load && (state_q == EMPTY) && !flush_i;
  assign snoop    = (state_q == WAIT) && !flush_i;

  rs_operand #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_src1 (
    .clk         (clk),
    .rst         (rst),
    .load        (load_acc),
    .src_rdy_i   (src1_rdy_i),
    .src_val_i   (src1_val_i),
    .src_tag_i   (src1_tag_i),
    .snoop       (snoop),
    .cdb_valid_i (cdb_valid_i),
    .cdb_tag_i   (cdb_tag_i),
    .cdb_val_i   (cdb_val_i),
    .rdy_nxt     (a_rdy_nxt),
    .val         (fu_a_o)
  );

  rs_operand #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_src2 (
    .clk         (clk),
    .rst         (rst),
    .load        (load_acc),
    .src_rdy_i   (src2_rdy_i),
    .src_val_i   (src2_val_i),
    .src_tag_i   (src2_tag_i),
    .snoop       (snoop),
    .cdb_valid_i (cdb_valid_i),
    .cdb_tag_i   (cdb_tag_i),
    .cdb_val_i   (cdb_val_i),
    .rdy_nxt     (b_rdy_nxt),
    .val         (fu_b_o)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (load_acc) state_d = (a_rdy_nxt && b_rdy_nxt) ? READY : WAIT;
      WAIT:  if (a_rdy_nxt && b_rdy_nxt) state_d = READY;
      READY: if (fu_ready_i) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (flush_i) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      op_q    <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_acc) begin
        op_q   <= op_i;
        dest_q <= dest_tag_i;
      end
    end
  end

  assign empty      = (state_q == EMPTY);
  assign fu_valid_o = (state_q == READY);
  assign fu_op_o    = op_q;
  assign fu_tag_o   = dest_q;

  // Upstream must only route to this station while it reports empty.
  a_no_load_when_busy : assert property (
    @(posedge clk) disable iff (rst) !(load && !flush_i && (state_q != EMPTY))
  );

endmodule

// File: doc/res_station.md
Name: res_station

Overview:
- Single-entry Tomasulo reservation station directly downstream of the instruction queue.
- Accepts one control word when its load strobe is pulsed and holds source operands as values or ROB tags.
- Snoops the common data bus (CDB) to resolve outstanding tags.
- Presents the fully-resolved operation to its functional unit with a valid/ready handshake; `empty` feeds the queue's routing logic.

Parameters:
- DATA_W, 32, operand/result width
- TAG_W, 3, ROB tag width (ROB depth = 2**TAG_W)
- OP_W, 4, width of the ALU operation code carried through

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- load  in  1  capture entry this cycle (from instruction queue)
- op_i  in  OP_W  ALU operation of incoming entry
- dest_tag_i  in  TAG_W  ROB tag allocated to incoming entry
- src1_rdy_i  in  1  src1 value valid at load
- src1_val_i  in  DATA_W  src1 value (used if src1_rdy_i)
- src1_tag_i  in  TAG_W  producing ROB tag (used if !src1_rdy_i)
- src2_rdy_i, src2_val_i, src2_tag_i  in  1/DATA_W/TAG_W  same for src2
- cdb_valid_i  in  1  CDB broadcast valid
- cdb_tag_i  in  TAG_W  broadcast ROB tag
- cdb_val_i  in  DATA_W  broadcast value
- flush_i  in  1  squash entry (mispredict)
- fu_ready_i  in  1  functional unit accepts
- empty  out  1  station free; to instruction queue resN_empty
- fu_valid_o  out  1  entry resolved, requesting issue
- fu_op_o  out  OP_W  held op
- fu_a_o, fu_b_o  out  DATA_W  held operands
- fu_tag_o  out  TAG_W  held dest tag

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- States: EMPTY, WAIT (≥1 operand pending), READY (both resolved, fu_valid_o high).
- Reset: state EMPTY; empty=1; fu_valid_o=0; all data/tag/op registers 0; operand ready bits 0.
- empty = (state==EMPTY), purely from state.
  - It does not go high in the fire cycle, so no load can coincide with issue.
- EMPTY & load:
  - Capture op, dest tag, per-operand ready/value/tag.
  - Next state READY if both operands ready after capture, else WAIT.
  - Load→fu_valid_o latency is 1 cycle when both operands are ready.
- Load while not EMPTY: ignored; entry unchanged (protocol violation, flagged by assertion).
- WAIT, CDB match:
  - Each unresolved operand whose tag == cdb_tag_i with cdb_valid_i latches cdb_val_i and sets its ready bit.
  - Both operands may match the same broadcast; both capture.
  - Transition to READY the cycle after the last operand resolves; CDB→fu_valid_o latency is 1 cycle.
- Resolved operands ignore the CDB; a tag match on a resolved operand has no effect.
- READY: fu_valid_o=1; op/operands/tag held stable until fire.
  - fire = fu_valid_o & fu_ready_i → next state EMPTY.
  - fu_valid_o never drops without fire, except on flush or reset.
- flush_i: next state EMPTY from any state, fu_valid_o=0 next cycle.
  - Overrides load, CDB capture and fire in the same cycle.
  - Data registers need not clear.
- rst overrides everything, including flush.
- Tag comparison is exact TAG_W equality; no wrap semantics apply.

Optional Feature:
- RS_CDB_BYPASS_EN
- Defined: on a load cycle, an operand with !srcN_rdy_i whose srcN_tag_i matches a valid CDB broadcast that same cycle captures cdb_val_i as resolved. The entry may enter READY directly.
- Undefined: load-cycle operands take srcN_* verbatim. Upstream must already present same-cycle CDB results as ready values, i.e. the regfile forwards writeback.

Decomposition:
- Shared package (tomasula_types): rs_state_t enum {EMPTY, WAIT, READY}; operand struct {rdy, val, tag}; TAG_W, DATA_W, OP_W constants.
- One natural sub-module: rs_operand, a single operand slot.
  - Handles load capture, CDB compare and capture, and optional bypass.
  - Instantiated twice.

Test Plan:
- Reset, then load op=ADD, src1 ready 5, src2 ready 7, tag 2 → next cycle fu_valid_o=1, fu_a_o=5, fu_b_o=7, fu_tag_o=2; with fu_ready_i=1 → empty=1 following cycle.
- Load src1 ready 3, src2 pending tag 4; CDB tag 3 then tag 4 val 0xDEAD → stays WAIT after tag 3; fu_valid_o=1 one cycle after tag 4 broadcast, fu_b_o=0xDEAD.
- Both sources pending tag 6; single CDB tag 6 val 9 → fu_a_o=fu_b_o=9, READY next cycle.
- READY with fu_ready_i=0 for 4 cycles → outputs stable, empty=0; CDB broadcast of an old tag → no change.
- Flush in WAIT while a matching CDB arrives, and separately flush concurrent with load → empty=1 next cycle, fu_valid_o=0.
- Load with src1 pending tag 1 while CDB tag 1 val 0x11 in the same cycle → READY next cycle with fu_a_o=0x11 if RS_CDB_BYPASS_EN is defined; stays WAIT otherwise.
